ram_bus_arbiter: RTL

- Two-requester arbiter that shares one native PicoRV32-style memory port (valid/ready, addr, wdata, wstrb, rdata) between master 0 (CPU) and master 1 (DMA or a second bus master).
- Sits between the requesters and the on-chip RAM/peripheral decode.
- Round-robin grant, held for one whole transaction.
- Optional watchdog terminates transactions the slave never acknowledges.

---
 rtl/ram_bus_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter sharing one PicoRV32-style native memory port.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        bus_timeout
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      r_state;
   logic [1:0]  r_grant;
   logic        r_last;

   logic        w_busy;
   logic        w_gvalid;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_rdata;

   assign w_busy   = (r_state == BUSY);
   assign w_gvalid = r_grant[1] ? m1_valid : m0_valid;

   assign s_valid = w_busy;
   assign s_addr  = r_grant[1] ? m1_addr  : m0_addr;
   assign s_wdata = r_grant[1] ? m1_wdata : m0_wdata;
   assign s_wstrb = r_grant[1] ? m1_wstrb : m0_wstrb;
   assign grant   = r_grant;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_cnt;

   // Counts BUSY cycles the slave has left unanswered; IDLE clears it so every grant starts from zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_cnt <= '0;
      end else if (!s_ready) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign w_timeout = w_busy && !s_ready && (r_cnt == TIMEOUT_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   assign bus_timeout = w_timeout;
   assign w_done      = w_busy && (s_ready || w_timeout);

   // A real slave answer always wins over the watchdog's substitute data.
   assign w_rdata  = s_ready ? s_rdata : TIMEOUT_RDATA;

   assign m0_ready = w_done && r_grant[0];
   assign m1_ready = w_done && r_grant[1];
   assign m0_rdata = m0_ready ? w_rdata : 32'd0;
   assign m1_rdata = m1_ready ? w_rdata : 32'd0;

   // Grant is held for one whole transaction; IDLE always follows so a waiting master gets its turn.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_grant <= 2'b00;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (m0_valid && m1_valid) begin
                  r_grant <= r_last ? 2'b01 : 2'b10;
                  r_state <= BUSY;
               end else if (m0_valid) begin
                  r_grant <= 2'b01;
                  r_state <= BUSY;
               end else if (m1_valid) begin
                  r_grant <= 2'b10;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_done) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_last  <= r_grant[1];
               end else if (!w_gvalid) begin
                  // Owner withdrew its request: drop the bus without touching fairness history.
                  r_state <= IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule
